seg_dync_capture: RTL and testbench
===================================

Name: seg_dync_capture

Overview:
- Monitor/receiver for the multiplexed 6-digit 7-segment display bus (sel/seg) driven by the dynamic scan driver.
- Watches the scanned sel/seg lines, decodes each digit's segment pattern back to BCD and reassembles the 24-bit displayed value.
- Flags undecodable patterns and a stalled scan.
- Used as an on-chip self-check of the display path and as the bench-side scoreboard front end.

Parameters:
- SETTLE, 16'd1_000: consecutive cycles a sel/seg pair must be unchanged before the digit is captured.
- TIMEOUT, 24'd1_000_000: maximum cycles between two completed frames before lost asserts.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sel  input  6  digit select, active-low one-hot; sel[0] = rightmost digit = num[3:0], sel[5] = num[23:20]
- seg  input  8  segments, active-low; seg[7]=dp (ignored), seg[6:0]=g..a
- num  output  24  last completed frame, 6 BCD nibbles
- num_vld  output  1  one-cycle pulse when num is updated
- bad_seg  output  1  sticky: undecodable pattern captured since reset
- lost  output  1  no completed frame within TIMEOUT cycles

Behaviour:
- Reset (async, rst_n=0): num=24'h0, num_vld=0, bad_seg=0, lost=0, FSM=SYNC, all internal counters and flags cleared. Effective immediately, including mid-frame; a partial frame is discarded.
- Input stage: sel and seg are registered once (sel_q, seg_q).
- Stability counter:
  - stab_cnt clears when {sel_q,seg_q} differs from the previous cycle's value, otherwise increments, saturating at SETTLE.
  - A capture event fires in the single cycle where stab_cnt reaches SETTLE-1 and sel_q is exactly one-hot-low.
  - At most one capture per dwell.
  - sel_q all-ones (blank) or with more than one low bit never captures.
- Decode of seg_q[6:0] to nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - Any other pattern decodes to 4'hF and sets bad_seg.
- FSM:
  - SYNC: ignore captures until a capture with digit index 0. Store that nibble, set done[0], go to COLLECT.
  - COLLECT: each capture writes its nibble into a frame buffer slot and sets done[idx].
    - A repeated index overwrites its slot.
    - When done becomes 6'b111111 (may be on the capture that sets the last bit), go to EMIT.
  - EMIT (one cycle): num <= frame buffer, num_vld=1, done cleared, timeout counter cleared, go to COLLECT.
    - A capture arriving during EMIT is not lost: it is applied to the fresh frame.
- Latency: num/num_vld change 2 cycles after the capture cycle of the final digit (capture cycle, then EMIT registered output).
- Timeout:
  - tmo_cnt increments every cycle and clears on EMIT.
  - When it reaches TIMEOUT-1, lost=1 and the FSM returns to SYNC with done cleared.
  - lost clears on the next EMIT.
  - num holds its last value while lost.
- num_vld pulses even if the value is unchanged from the previous frame.
- Widths: stab_cnt 16 bits, tmo_cnt 24 bits; parameter values must fit these widths. SETTLE ≥ 2.

Test Plan:
- Scan 12:34:56 (num bus 0x123456), 6 digits × 2000-cycle dwell, SETTLE=1000 -> num=24'h123456 with one num_vld pulse per full scan; first pulse after the first complete frame starting at sel=6'b111110.
- Mid-dwell glitch: seg changes for 10 cycles inside a dwell, then returns -> no extra capture; num unaffected; bad_seg stays 0.
- Digit 3 driven seg=8'hFF for a whole dwell -> num[15:12]=4'hF, bad_seg=1 and remains 1 across later good frames until rst_n=0.
- Scanning starts at sel=6'b110111 -> no num_vld until digit 0 is seen; first frame completes 6 dwells after digit 0.
- Scan stops (sel=6'b111111) with TIMEOUT=5000 -> lost=1 exactly 5000 cycles after the last EMIT, num holds 24'h123456; resume scan -> lost=0 at next num_vld.
- rst_n pulsed low during digit 4 -> all outputs 0 immediately; after release the FSM resyncs on digit 0 and reports the correct value.

Source files
------------

// File: rtl/seg_dync_capture.sv
// Receiver for a scanned 6-digit active-low 7-segment bus: debounces each digit dwell,
// decodes segments back to BCD and reassembles complete frames into num.
module seg_dync_capture #(
    parameter logic [15:0] SETTLE  = 16'd1_000,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  sel,
    input  logic [7:0]  seg,
    output logic [23:0] num,
    output logic        num_vld,
    output logic        bad_seg,
    output logic        lost
);
    typedef enum logic [1:0] {SYNC, COLLECT, EMIT} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;
    logic [15:0] stab_cnt;
    logic [23:0] tmo_cnt;
    logic [5:0]  done_reg, done_next;
    logic [23:0] frame_reg;
    logic [5:0]  inv_sel, dig_bit;
    logic [2:0]  idx;
    logic [3:0]  nib;
    logic        nib_bad, onehot, same, cap, tmo_hit, wr, emit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 6'h3F;
            seg_q <= 8'hFF;
            sel_d <= 6'h3F;
            seg_d <= 8'hFF;
        end else begin
            sel_q <= sel;
            seg_q <= seg;
            sel_d <= sel_q;
            seg_d <= seg_q;
        end
    end

    assign same    = ({sel_q, seg_q} == {sel_d, seg_d});
    assign inv_sel = ~sel_q;
    assign onehot  = (inv_sel != 6'd0) && ((inv_sel & (inv_sel - 6'd1)) == 6'd0);
    // Fires once per dwell: the counter passes SETTLE-1 only once before saturating.
    assign cap     = same && (stab_cnt == SETTLE - 16'd1) && onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= 16'd0;
        end else if (!same) begin
            stab_cnt <= 16'd0;
        end else if (stab_cnt != SETTLE) begin
            stab_cnt <= stab_cnt + 16'd1;
        end
    end

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!sel_q[i]) idx = 3'(i);
        end
    end
    assign dig_bit = 6'd1 << idx;

    always_comb begin
        nib_bad = 1'b0;
        case (seg_q[6:0])
            7'h40:   nib = 4'd0;
            7'h79:   nib = 4'd1;
            7'h24:   nib = 4'd2;
            7'h30:   nib = 4'd3;
            7'h19:   nib = 4'd4;
            7'h12:   nib = 4'd5;
            7'h02:   nib = 4'd6;
            7'h78:   nib = 4'd7;
            7'h00:   nib = 4'd8;
            7'h10:   nib = 4'd9;
            default: begin
                nib     = 4'hF;
                nib_bad = 1'b1;
            end
        endcase
    end

    assign emit    = (state_reg == EMIT);
    assign tmo_hit = (tmo_cnt == TIMEOUT - 24'd1);

    always_comb begin
        state_next = state_reg;
        done_next  = done_reg;
        wr         = 1'b0;
        case (state_reg)
            SYNC: begin
                if (cap && idx == 3'd0) begin
                    wr         = 1'b1;
                    done_next  = 6'b000001;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (cap) begin
                    wr        = 1'b1;
                    done_next = done_reg | dig_bit;
                    if (done_next == 6'h3F) state_next = EMIT;
                end
            end
            default: begin
                // A capture landing on the emit cycle starts the next frame.
                state_next = COLLECT;
                done_next  = 6'd0;
                if (cap) begin
                    wr        = 1'b1;
                    done_next = dig_bit;
                end
            end
        endcase
        if (tmo_hit && !emit) begin
            state_next = SYNC;
            done_next  = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SYNC;
            done_reg  <= 6'd0;
            tmo_cnt   <= 24'd0;
            num       <= 24'h0;
            num_vld   <= 1'b0;
            bad_seg   <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            num_vld   <= emit;
            if (emit) num <= frame_reg;
            if (cap && nib_bad) bad_seg <= 1'b1;
            if (emit) begin
                tmo_cnt <= 24'd0;
                lost    <= 1'b0;
            end else begin
                if (tmo_cnt != TIMEOUT) tmo_cnt <= tmo_cnt + 24'd1;
                if (tmo_hit) lost <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    frame_reg[gi*4 +: 4] <= 4'h0;
                end else if (wr && idx == gi) begin
                    frame_reg[gi*4 +: 4] <= nib;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_seg_dync_capture.sv
// Directed bench for seg_dync_capture: scanned frames, glitch, bad pattern, late start,
// scan stall timeout and mid-frame reset.
module tb_seg_dync_capture;
    localparam int DWELL = 200;
    localparam int TMO   = 5000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  sel = 6'h3F;
    logic [7:0]  seg = 8'hFF;
    logic [23:0] num;
    logic        num_vld, bad_seg, lost;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    seg_dync_capture #(.SETTLE(16'd100), .TIMEOUT(24'd5000)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .seg(seg),
        .num(num), .num_vld(num_vld), .bad_seg(bad_seg), .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 8'hC0;
            4'd1: enc = 8'hF9;
            4'd2: enc = 8'hA4;
            4'd3: enc = 8'hB0;
            4'd4: enc = 8'h99;
            4'd5: enc = 8'h92;
            4'd6: enc = 8'h82;
            4'd7: enc = 8'hF8;
            4'd8: enc = 8'h80;
            default: enc = 8'h90;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic dwell(input int idx, input logic [7:0] pat, input int cycles);
        sel = ~(6'd1 << idx);
        seg = pat;
        repeat (cycles) begin
            @(negedge clk);
            if (num_vld) pulses++;
        end
    endtask

    task automatic scan(input logic [23:0] v, input int first, input int bad_dig, input int glitch_dig);
        logic [7:0] pat;
        for (int i = first; i < 6; i++) begin
            pat = (i == bad_dig) ? 8'hFF : enc(v[i*4 +: 4]);
            if (i == glitch_dig) begin
                dwell(i, pat, 150);
                dwell(i, 8'h80, 10);
                dwell(i, pat, DWELL - 160);
            end else begin
                dwell(i, pat, DWELL);
            end
        end
    endtask

    initial begin
        int k;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_num", 32'(num), 32'h0);
        chk("rst_vld", 32'(num_vld), 32'h0);
        chk("rst_bad", 32'(bad_seg), 32'h0);
        chk("rst_lost", 32'(lost), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // scanning begins at digit 3: nothing until digit 0 has been seen
        pulses = 0;
        scan(24'h123456, 3, -1, -1);
        chk("late_start_nopulse", 32'(pulses), 32'd0);
        for (int i = 0; i < 5; i++) dwell(i, enc(4'(24'h123456 >> (i*4))), DWELL);
        chk("five_dwells_nopulse", 32'(pulses), 32'd0);
        dwell(5, enc(4'd1), DWELL);
        chk("first_frame_pulse", 32'(pulses), 32'd1);
        chk("first_frame_num", 32'(num), 32'h123456);

        // glitch inside digit 2 dwell
        pulses = 0;
        scan(24'h123456, 0, -1, 2);
        chk("glitch_pulse", 32'(pulses), 32'd1);
        chk("glitch_num", 32'(num), 32'h123456);
        chk("glitch_bad", 32'(bad_seg), 32'h0);

        // undecodable digit 3, then a good frame keeps bad_seg sticky
        pulses = 0;
        scan(24'h123456, 0, 3, -1);
        chk("badseg_num", 32'(num), 32'h12F456);
        chk("badseg_flag", 32'(bad_seg), 32'h1);
        scan(24'h654321, 0, -1, -1);
        chk("after_bad_num", 32'(num), 32'h654321);
        chk("after_bad_flag", 32'(bad_seg), 32'h1);
        chk("two_frame_pulses", 32'(pulses), 32'd2);

        // scan stalls right after an emit
        for (int i = 0; i < 5; i++) dwell(i, enc(4'(24'h123456 >> (i*4))), DWELL);
        sel = 6'b011111;
        seg = enc(4'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!num_vld && k < 2 * DWELL);
        chk("stall_emit_seen", 32'(num_vld), 32'h1);
        sel = 6'h3F;
        seg = 8'hFF;
        repeat (TMO - 1) @(negedge clk);
        chk("lost_before", 32'(lost), 32'h0);
        @(negedge clk);
        chk("lost_at_tmo", 32'(lost), 32'h1);
        chk("lost_num_hold", 32'(num), 32'h123456);
        pulses = 0;
        scan(24'h123456, 0, -1, -1);
        chk("resume_pulse", 32'(pulses), 32'd1);
        chk("resume_lost", 32'(lost), 32'h0);

        // reset pulsed during digit 4
        for (int i = 0; i < 4; i++) dwell(i, enc(4'(24'h987650 >> (i*4))), DWELL);
        dwell(4, enc(4'd8), 50);
        rst_n = 1'b0;
        #1;
        chk("midrst_num", 32'(num), 32'h0);
        chk("midrst_bad", 32'(bad_seg), 32'h0);
        chk("midrst_lost", 32'(lost), 32'h0);
        chk("midrst_vld", 32'(num_vld), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        dwell(4, enc(4'd8), DWELL);
        dwell(5, enc(4'd9), DWELL);
        chk("midrst_nopulse", 32'(pulses), 32'd0);
        scan(24'h987650, 0, -1, -1);
        chk("resync_pulse", 32'(pulses), 32'd1);
        chk("resync_num", 32'(num), 32'h987650);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
